// File: rtl/pattern_serializer_pkg.sv
// Shared definitions for the serial-sequence blocks: state encoding,
// default widths and a small width helper.
package pattern_serializer_pkg;

  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABORT = 2'd3
  } ser_state_t;

  // Bit-index width for a pattern of w bits (never narrower than 1).
  function automatic int idx_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/frame_counter.sv
// Bit-index and repetition down-counters for one serial frame:
// load, decrement, wrap between repetitions, and a last-bit flag.
module frame_counter
  import pattern_serializer_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  localparam int IDX_W = idx_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] rep_in,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] REP_ONE = CNT_W'(1);

  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] rep_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      rep_q <= '0;
    end else if (load) begin
      idx_q <= IDX_TOP;
      // A requested count of zero still sends the pattern once.
      rep_q <= (rep_in == '0) ? REP_ONE : rep_in;
    end else if (dec) begin
      if (idx_q == '0) begin
        idx_q <= IDX_TOP;
        rep_q <= rep_q - REP_ONE;
      end else begin
        idx_q <= idx_q - 1'b1;
      end
    end
  end

  assign idx  = idx_q;
  assign last = (idx_q == '0) && (rep_q <= REP_ONE);

endmodule

// File: rtl/pattern_serializer.sv
// Sends a captured pattern MSB first, repeated back to back, as a serial
// bit stream with frame-level done/aborted pulses.
module pattern_serializer
  import pattern_serializer_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             abort,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output ser_state_t       dbg_state
);

  localparam int IDX_W = idx_w(PAT_W);

  // Handshake: a request transfers on a rising edge where load_valid and
  // load_ready are both high; load_ready is high only in IDLE, and
  // load_valid seen while load_ready is low is dropped, never queued.

  ser_state_t       state_q, state_d;
  logic [PAT_W-1:0] pat_q;
  logic [IDX_W-1:0] idx;
  logic             last;
  logic             accept;
  logic             cnt_dec;

  assign accept  = (state_q == ST_IDLE) && load_valid;
  assign cnt_dec = (state_q == ST_SHIFT) && !abort && !last;

  frame_counter #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) u_frame_counter (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .dec    (cnt_dec),
    .rep_in (repeat_cnt),
    .idx    (idx),
    .last   (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) pat_q <= pattern;
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:  state_d = load_valid ? ST_SHIFT : ST_IDLE;
      // Abort takes priority over the final-bit transition.
      ST_SHIFT: begin
        if (abort)     state_d = ST_ABORT;
        else if (last) state_d = ST_DONE;
        else           state_d = ST_SHIFT;
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    x          = 1'b0;
    x_valid    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    aborted    = 1'b0;
    case (state_q)
      ST_IDLE:  load_ready = 1'b1;
      ST_SHIFT: begin
        x       = pat_q[idx];
        x_valid = 1'b1;
        busy    = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
        busy = 1'b1;
      end
      ST_ABORT: begin
        aborted = 1'b1;
        busy    = 1'b1;
      end
      default:  load_ready = 1'b1;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Directed and randomized frames checked against a bit-list model of the
// serializer plus an overlapping 1010 detector fed from x.
module tb_pattern_serializer;
  import pattern_serializer_pkg::*;

  localparam int PAT_W = 4;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             load_valid;
  logic             load_ready;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic             abort;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;
  logic             aborted;
  ser_state_t       dbg_state;

  int tests = 0;
  int fails = 0;

  pattern_serializer #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .abort      (abort),
    .x          (x),
    .x_valid    (x_valid),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .dbg_state  (dbg_state)
  );

  // Clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard helpers
  task automatic check_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_bit({tag, "_ready"},   load_ready, 1'b1);
    check_bit({tag, "_x"},       x,          1'b0);
    check_bit({tag, "_xvalid"},  x_valid,    1'b0);
    check_bit({tag, "_busy"},    busy,       1'b0);
    check_bit({tag, "_done"},    done,       1'b0);
    check_bit({tag, "_aborted"}, aborted,    1'b0);
  endtask

  // Drives one request and checks the whole frame. abort_at is the frame
  // bit during which abort is raised (-1 for none); hold keeps load_valid
  // high and scrambles pattern/repeat_cnt while the frame runs.
  task automatic run_frame(input string tag, input logic [PAT_W-1:0] pat,
                           input logic [CNT_W-1:0] rep, input int abort_at,
                           input bit hold, output int ycnt);
    logic exp_q[$];
    logic [3:0] hist;
    int reps;
    int n;
    reps = (rep == 0) ? 1 : int'(rep);
    exp_q = {};
    for (int r = 0; r < reps; r++)
      for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back(pat[b]);
    n = exp_q.size();
    ycnt = 0;
    hist = 4'b0000;

    check_bit({tag, "_ready_pre"}, load_ready, 1'b1);
    load_valid = 1'b1;
    pattern    = pat;
    repeat_cnt = rep;
    tick();
    if (!hold) load_valid = 1'b0;

    for (int i = 0; i < n; i++) begin
      check_bit({tag, "_xvalid"},  x_valid,    1'b1);
      check_bit({tag, "_x"},       x,          exp_q[i]);
      check_bit({tag, "_busy"},    busy,       1'b1);
      check_bit({tag, "_ready"},   load_ready, 1'b0);
      check_bit({tag, "_done"},    done,       1'b0);
      check_bit({tag, "_aborted"}, aborted,    1'b0);
      if ({hist[2:0], x} == 4'b1010) ycnt++;
      hist = {hist[2:0], x};
      if (hold) begin
        pattern    = PAT_W'($urandom);
        repeat_cnt = CNT_W'($urandom);
      end
      if (i == abort_at) abort = 1'b1;
      tick();
      abort = 1'b0;
      if (i == abort_at) begin
        check_bit({tag, "_ab_pulse"},  aborted, 1'b1);
        check_bit({tag, "_ab_xvalid"}, x_valid, 1'b0);
        check_bit({tag, "_ab_x"},      x,       1'b0);
        check_bit({tag, "_ab_busy"},   busy,    1'b1);
        check_bit({tag, "_ab_done"},   done,    1'b0);
        abort = 1'($urandom_range(0, 1));
        tick();
        abort = 1'b0;
        check_idle({tag, "_ab_idle"});
        if (!hold) load_valid = 1'b0;
        return;
      end
    end

    check_bit({tag, "_dn_pulse"},   done,       1'b1);
    check_bit({tag, "_dn_xvalid"},  x_valid,    1'b0);
    check_bit({tag, "_dn_x"},       x,          1'b0);
    check_bit({tag, "_dn_busy"},    busy,       1'b1);
    check_bit({tag, "_dn_ready"},   load_ready, 1'b0);
    check_bit({tag, "_dn_aborted"}, aborted,    1'b0);
    abort = 1'($urandom_range(0, 1));
    tick();
    abort = 1'b0;
    check_idle({tag, "_dn_idle"});
  endtask

  initial begin
    int y;
    int reps;
    int ab;
    logic [PAT_W-1:0] rp;
    logic [CNT_W-1:0] rc;

    rst        = 1'b1;
    load_valid = 1'b0;
    pattern    = '0;
    repeat_cnt = '0;
    abort      = 1'b0;
    #2;
    check_idle("reset");
    tick();
    #2 rst = 1'b0;
    tick();
    check_idle("post_reset");

    // Abort while idle has no effect.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("idle_abort");

    run_frame("loop1", 4'b1010, 4'd1, -1, 1'b0, y);
    check_int("loop1_y", y, 1);
    run_frame("loop3", 4'b1010, 4'd3, -1, 1'b0, y);
    check_int("loop3_y", y, 5);
    run_frame("rep0", 4'b1101, 4'd0, -1, 1'b0, y);
    run_frame("rep1", 4'b1101, 4'd1, -1, 1'b0, y);
    run_frame("abort2", 4'b1010, 4'd2, 1, 1'b0, y);
    run_frame("abort_last", 4'b0111, 4'd1, 3, 1'b0, y);
    run_frame("hold", 4'b1001, 4'd2, -1, 1'b1, y);
    run_frame("after_hold", 4'b0011, 4'd2, -1, 1'b0, y);

    // Reset in the middle of bit 3 of a frame.
    load_valid = 1'b1;
    pattern    = 4'b1010;
    repeat_cnt = 4'd2;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    check_bit("pre_rst_xvalid", x_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_idle("async_rst");
    tick();
    check_idle("rst_held");
    rst = 1'b0;
    tick();
    check_idle("rst_release");
    run_frame("post_rst", 4'b0110, 4'd1, -1, 1'b0, y);

    // Randomized frames, back to back.
    for (int k = 0; k < 25; k++) begin
      rp   = PAT_W'($urandom);
      rc   = CNT_W'($urandom_range(0, 4));
      reps = (rc == 0) ? 1 : int'(rc);
      ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, PAT_W * reps - 1)) : -1;
      run_frame("rand", rp, rc, ab, 1'($urandom_range(0, 1)), y);
    end
    load_valid = 1'b0;
    tick();
    check_idle("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
